cpu: RTL and testbench



---
 rtl/cpu.sv | 211 +++++++++++++++++++++
 tb/tb_cpu.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// cpu: 5-stage in-order MIPS-subset pipeline (IF/ID/EX/MEM/WB) with no hazard handling.
// Optional macro REGFILE_BYPASS_EN: WB writes are visible to same-cycle ID reads (write-first).
module cpu #(
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 32,
    parameter int WIDTH      = 32
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             LoadInstructions,
    input  logic [31:0]      Instruction,
    output logic [WIDTH-1:0] out
);

    localparam int IA = $clog2(IMEM_DEPTH);
    localparam int DA = $clog2(DMEM_DEPTH);

    typedef enum logic [2:0] {
        ALU_ZERO, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    typedef struct packed {
        alu_op_t          alu;
        logic             use_imm;
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic [4:0]       dest;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] imm;
    } id_ex_t;

    typedef struct packed {
        logic             mem_read;
        logic             mem_write;
        logic             reg_write;
        logic [4:0]       dest;
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] store;
    } ex_mem_t;

    typedef struct packed {
        logic             reg_write;
        logic [4:0]       dest;
        logic [WIDTH-1:0] result;
    } mem_wb_t;

    logic [31:0]      imem [IMEM_DEPTH];
    logic [WIDTH-1:0] dmem_enc [DMEM_DEPTH];
    logic [WIDTH-1:0] regs [32];

    logic [IA-1:0] pc;
    logic [IA-1:0] load_cnt;
    logic [31:0]   if_id_instr;
    id_ex_t        id_ex;
    id_ex_t        id_next;
    ex_mem_t       ex_mem;
    ex_mem_t       ex_mem_next;
    mem_wb_t       mem_wb;

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [WIDTH-1:0] imm_ext;
    logic [WIDTH-1:0] rs_val;
    logic [WIDTH-1:0] rt_val;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] ex_result;
    logic [DA-1:0]    mem_addr;
    logic             wb_we;
    logic [4:0]       unused_shamt;

    assign opcode       = if_id_instr[31:26];
    assign rs           = if_id_instr[25:21];
    assign rt           = if_id_instr[20:16];
    assign rd           = if_id_instr[15:11];
    assign unused_shamt = if_id_instr[10:6];
    assign funct        = if_id_instr[5:0];
    assign imm_ext      = {{(WIDTH-16){if_id_instr[15]}}, if_id_instr[15:0]};

    assign wb_we    = mem_wb.reg_write && (mem_wb.dest != 5'd0) && !LoadInstructions;
    assign mem_addr = ex_mem.result[DA-1:0];
    assign out      = mem_wb.result;

    // Instruction memory: serial load port, never touched by reset.
    always_ff @(posedge clk) begin
        if (Reset && LoadInstructions)
            imem[load_cnt] <= Instruction;
    end

    // Data memory holds data XOR address, so all-zero power-up content reads back as mem[i] = i.
    always_ff @(posedge clk) begin
        if (Reset && !LoadInstructions && ex_mem.mem_write)
            dmem_enc[mem_addr] <= ex_mem.store ^ WIDTH'(mem_addr);
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_we) begin
            regs[mem_wb.dest] <= mem_wb.result;
        end
    end

    always_comb begin
        rs_val = regs[rs];
        rt_val = regs[rt];
`ifdef REGFILE_BYPASS_EN
        if (wb_we && mem_wb.dest == rs)
            rs_val = mem_wb.result;
        if (wb_we && mem_wb.dest == rt)
            rt_val = mem_wb.result;
`endif
    end

    // Decode: unrecognised opcodes and functs fall through as bubbles.
    always_comb begin
        id_next     = '0;
        id_next.a   = rs_val;
        id_next.b   = rt_val;
        id_next.imm = imm_ext;
        id_next.dest = rd;
        case (opcode)
            6'h00: begin
                id_next.reg_write = 1'b1;
                case (funct)
                    6'h20:   id_next.alu = ALU_ADD;
                    6'h22:   id_next.alu = ALU_SUB;
                    6'h24:   id_next.alu = ALU_AND;
                    6'h25:   id_next.alu = ALU_OR;
                    6'h2A:   id_next.alu = ALU_SLT;
                    default: id_next.reg_write = 1'b0;
                endcase
            end
            6'h08: begin
                id_next.alu       = ALU_ADD;
                id_next.use_imm   = 1'b1;
                id_next.reg_write = 1'b1;
                id_next.dest      = rt;
            end
            6'h23: begin
                id_next.alu       = ALU_ADD;
                id_next.use_imm   = 1'b1;
                id_next.mem_read  = 1'b1;
                id_next.reg_write = 1'b1;
                id_next.dest      = rt;
            end
            6'h2B: begin
                id_next.alu       = ALU_ADD;
                id_next.use_imm   = 1'b1;
                id_next.mem_write = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        op_b      = id_ex.use_imm ? id_ex.imm : id_ex.b;
        ex_result = '0;
        case (id_ex.alu)
            ALU_ADD: ex_result = id_ex.a + op_b;
            ALU_SUB: ex_result = id_ex.a - op_b;
            ALU_AND: ex_result = id_ex.a & op_b;
            ALU_OR:  ex_result = id_ex.a | op_b;
            ALU_SLT: ex_result = {{(WIDTH-1){1'b0}}, ($signed(id_ex.a) < $signed(op_b))};
            default: ex_result = '0;
        endcase
    end

    always_comb begin
        ex_mem_next           = '0;
        ex_mem_next.mem_read  = id_ex.mem_read;
        ex_mem_next.mem_write = id_ex.mem_write;
        ex_mem_next.reg_write = id_ex.reg_write;
        ex_mem_next.dest      = id_ex.dest;
        ex_mem_next.result    = ex_result;
        ex_mem_next.store     = id_ex.b;
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            pc          <= '0;
            load_cnt    <= '0;
            if_id_instr <= '0;
            id_ex       <= '0;
            ex_mem      <= '0;
            mem_wb      <= '0;
        end else if (LoadInstructions) begin
            pc          <= '0;
            load_cnt    <= (load_cnt == IA'(IMEM_DEPTH - 1)) ? '0 : load_cnt + IA'(1);
            if_id_instr <= '0;
            id_ex       <= '0;
            ex_mem      <= '0;
            mem_wb      <= '0;
        end else begin
            pc               <= (pc == IA'(IMEM_DEPTH - 1)) ? '0 : pc + IA'(1);
            if_id_instr      <= imem[pc];
            id_ex            <= id_next;
            ex_mem           <= ex_mem_next;
            mem_wb.reg_write <= ex_mem.reg_write;
            mem_wb.dest      <= ex_mem.dest;
            mem_wb.result    <= ex_mem.mem_read ? (dmem_enc[mem_addr] ^ WIDTH'(mem_addr))
                                                : ex_mem.result;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: scoreboard bench for the cpu pipeline; expected write-back values are queued at load time.
module tb_cpu;

    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    logic        clk = 1'b0;
    logic        Reset;
    logic        LoadInstructions;
    logic [31:0] Instruction;
    logic [31:0] out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

    cpu #(.IMEM_DEPTH(32), .DMEM_DEPTH(32), .WIDTH(32)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .LoadInstructions (LoadInstructions),
        .Instruction      (Instruction),
        .out              (out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [5:0] funct);
        return {6'h00, rs, rt, rd, 5'h00, funct};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                          input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Called just after a rising edge; the pulse ends before the next edge.
    task automatic pulse_reset();
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
    endtask

    task automatic load_word(input logic [31:0] w, input logic [31:0] expected);
        Instruction      = w;
        LoadInstructions = 1'b1;
        exp_q.push_back(expected);
        @(posedge clk);
        #1;
    endtask

    task automatic end_load();
        LoadInstructions = 1'b0;
        Instruction      = 32'h0;
    endtask

    task automatic test_reset();
        Reset            = 1'b0;
        LoadInstructions = 1'b0;
        Instruction      = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out !== 32'h0) begin
            errors++;
            $display("FAIL reset_out got 0x%08h expected 0x00000000", out);
        end else $display("reset_out = 0x%08h", out);
        Reset = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out !== 32'h0) begin
                errors++;
                $display("FAIL empty_imem edge %0d got 0x%08h expected 0x00000000", e, out);
            end else $display("empty_imem edge %0d out = 0x%08h", e, out);
        end
    endtask

    task automatic test_program();
        pulse_reset();
        load_word(enc_i(OP_ADDI, 5'd1, 5'd0, 16'd423), 32'd423);
        load_word(enc_i(OP_ADDI, 5'd2, 5'd0, 16'd92),  32'd92);
        load_word(enc_i(OP_ADDI, 5'd3, 5'd0, 16'd13),  32'd13);
        load_word(enc_i(OP_ADDI, 5'd4, 5'd0, 16'd146), 32'd146);
        load_word(enc_i(OP_ADDI, 5'd5, 5'd0, 16'd5),   32'd5);
        load_word(enc_r(5'd5, 5'd1, 5'd4, F_ADD),      32'd423);
        load_word(enc_r(5'd6, 5'd3, 5'd5, F_SLT),      32'd0);
        load_word(enc_i(OP_LW, 5'd4, 5'd0, 16'd4),     32'd4);
        load_word(enc_r(5'd7, 5'd4, 5'd6, F_SUB),      32'd146);
        load_word(enc_i(OP_SW, 5'd7, 5'd0, 16'd0),     32'd0);
        load_word(enc_r(5'd8, 5'd7, 5'd2, F_ADD),      32'd92);
        end_load();
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        pulse_reset();
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            if (e >= 4) begin
                exp = exp_q.pop_front();
                checks++;
                if (out !== exp) begin
                    errors++;
                    $display("FAIL program edge %0d got %0d expected %0d", e, out, exp);
                end else $display("program edge %0d out = %0d", e, out);
            end
        end
    endtask

    task automatic test_midrun_reset();
        pulse_reset();
        exp_q.push_back(32'd423);
        exp_q.push_back(32'd92);
        exp_q.push_back(32'd13);
        exp_q.push_back(32'd146);
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk);
            #1;
            if (e >= 4) begin
                exp = exp_q.pop_front();
                checks++;
                if (out !== exp) begin
                    errors++;
                    $display("FAIL midrun_pre edge %0d got %0d expected %0d", e, out, exp);
                end else $display("midrun_pre edge %0d out = %0d", e, out);
            end
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (out !== 32'h0) begin
            errors++;
            $display("FAIL midrun_async_clear got %0d expected 0", out);
        end else $display("midrun_async_clear out = %0d", out);
        #1;
        Reset = 1'b1;
        exp_q.push_back(32'd423);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (e >= 4) begin
                exp = exp_q.pop_front();
                checks++;
                if (out !== exp) begin
                    errors++;
                    $display("FAIL midrun_restart edge %0d got %0d expected %0d", e, out, exp);
                end else $display("midrun_restart edge %0d out = %0d", e, out);
            end
        end
    endtask

    task automatic test_mem_alu();
        pulse_reset();
        load_word(enc_i(OP_ADDI, 5'd1, 5'd0, 16'd77),   32'd77);
        load_word(enc_i(OP_ADDI, 5'd2, 5'd0, 16'hFFF0), 32'hFFFF_FFF0);
        load_word(32'h0, 32'd0);
        load_word(32'h0, 32'd0);
        load_word(enc_i(OP_SW, 5'd1, 5'd0, 16'd5),      32'd5);
        load_word(enc_i(OP_LW, 5'd3, 5'd0, 16'd5),      32'd77);
        load_word(enc_i(OP_LW, 5'd4, 5'd0, 16'd6),      32'd6);
        load_word(enc_r(5'd5, 5'd1, 5'd2, F_AND),       32'd64);
        load_word(enc_r(5'd6, 5'd1, 5'd2, F_OR),        32'hFFFF_FFFD);
        load_word(enc_r(5'd7, 5'd2, 5'd1, F_SLT),       32'd1);
        load_word(enc_r(5'd8, 5'd1, 5'd2, F_SUB),       32'd93);
        load_word(enc_i(OP_LW, 5'd9, 5'd1, 16'hFFFF),   32'd12);
        end_load();
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk);
            #1;
            if (e >= 4) begin
                exp = exp_q.pop_front();
                checks++;
                if (out !== exp) begin
                    errors++;
                    $display("FAIL mem_alu edge %0d got 0x%08h expected 0x%08h", e, out, exp);
                end else $display("mem_alu edge %0d out = 0x%08h", e, out);
            end
        end
    endtask

    task automatic test_r0_unknown();
        pulse_reset();
        load_word(enc_i(OP_ADDI, 5'd0, 5'd0, 16'd7), 32'd7);
        load_word(32'h0, 32'd0);
        load_word(32'h0, 32'd0);
        load_word(32'h0, 32'd0);
        load_word(enc_r(5'd9, 5'd0, 5'd0, F_ADD),   32'd0);
        load_word(enc_i(6'h3F, 5'd11, 5'd0, 16'd9), 32'd0);
        load_word(enc_r(5'd12, 5'd0, 5'd0, 6'h21),  32'd0);
        end_load();
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (e >= 4) begin
                exp = exp_q.pop_front();
                checks++;
                if (out !== exp) begin
                    errors++;
                    $display("FAIL r0_unknown edge %0d got %0d expected %0d", e, out, exp);
                end else $display("r0_unknown edge %0d out = %0d", e, out);
            end
        end
    endtask

    task automatic test_load_wrap();
        pulse_reset();
        for (int i = 0; i < 33; i++) begin
            Instruction      = (i == 0)  ? enc_i(OP_ADDI, 5'd1, 5'd0, 16'd111) :
                               (i == 32) ? enc_i(OP_ADDI, 5'd1, 5'd0, 16'd222) : 32'h0;
            LoadInstructions = 1'b1;
            @(posedge clk);
            #1;
        end
        end_load();
        // Execution order: overwritten word 0, 31 NOPs, then word 0 again after the PC wraps.
        exp_q.push_back(32'd222);
        for (int i = 1; i < 32; i++) exp_q.push_back(32'd0);
        exp_q.push_back(32'd222);
        for (int e = 1; e <= 36; e++) begin
            @(posedge clk);
            #1;
            if (e >= 4) begin
                exp = exp_q.pop_front();
                checks++;
                if (out !== exp) begin
                    errors++;
                    $display("FAIL load_wrap edge %0d got %0d expected %0d", e, out, exp);
                end else $display("load_wrap edge %0d out = %0d", e, out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_midrun_reset();
        test_mem_alu();
        test_r0_unknown();
        test_load_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
